// File: rtl/micro_pkg.sv
// Shared encodings for the microprogram sequencer: sequencing field, opcodes
// and the fixed micro-state addresses the dispatch tables point at.
package micro_pkg;

    localparam logic [1:0] AC_FETCH = 2'd0;
    localparam logic [1:0] AC_DISP1 = 2'd1;
    localparam logic [1:0] AC_DISP2 = 2'd2;
    localparam logic [1:0] AC_SEQ   = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] US_FETCH   = 4'd0;
    localparam logic [3:0] US_DECODE  = 4'd1;
    localparam logic [3:0] US_MEMADR  = 4'd2;
    localparam logic [3:0] US_MEMRD   = 4'd3;
    localparam logic [3:0] US_MEMWB   = 4'd4;
    localparam logic [3:0] US_MEMWR   = 4'd5;
    localparam logic [3:0] US_EXECUTE = 4'd6;
    localparam logic [3:0] US_ALUWB   = 4'd7;
    localparam logic [3:0] US_BRANCH  = 4'd8;
    localparam logic [3:0] US_JUMP    = 4'd9;

endpackage

// File: rtl/micro_sequencer_dispatch_rom.sv
// Combinational opcode dispatch table. TABLE selects the first (decode) or
// second (memory op) stage; o_hit is low for opcodes the table does not decode.
module dispatch_rom
    import micro_pkg::*;
#(
    parameter int TABLE  = 1,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 6
) (
    input  logic [OP_W-1:0]   i_op_code,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_hit
);

    // Table lookup; misses report address zero and leave trapping to the caller.
    always_comb begin
        o_addr = {ADDR_W{1'b0}};
        o_hit  = 1'b0;
        if (TABLE == 1) begin
            case (i_op_code)
                OP_W'(OP_RTYPE): begin o_addr = ADDR_W'(US_EXECUTE); o_hit = 1'b1; end
                OP_W'(OP_J):     begin o_addr = ADDR_W'(US_JUMP);    o_hit = 1'b1; end
                OP_W'(OP_BEQ):   begin o_addr = ADDR_W'(US_BRANCH);  o_hit = 1'b1; end
                OP_W'(OP_LW):    begin o_addr = ADDR_W'(US_MEMADR);  o_hit = 1'b1; end
                OP_W'(OP_SW):    begin o_addr = ADDR_W'(US_MEMADR);  o_hit = 1'b1; end
                default:         begin o_addr = {ADDR_W{1'b0}};      o_hit = 1'b0; end
            endcase
        end else begin
            case (i_op_code)
                OP_W'(OP_LW): begin o_addr = ADDR_W'(US_MEMRD); o_hit = 1'b1; end
                OP_W'(OP_SW): begin o_addr = ADDR_W'(US_MEMWR); o_hit = 1'b1; end
                default:      begin o_addr = {ADDR_W{1'b0}};    o_hit = 1'b0; end
            endcase
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered micro-PC with sequential, fetch and
// two-stage opcode dispatch, sticky illegal-opcode trap, stall and retire count.
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int              ADDR_W    = 4,
    parameter int              OP_W      = 6,
    parameter int              CNT_W     = 16,
    parameter logic [ADDR_W-1:0] TRAP_ADDR = ADDR_W'((2 ** ADDR_W) - 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   op_code,
    input  logic [1:0]        addr_ctl,
    input  logic              stall,
    output logic [ADDR_W-1:0] upc,
    output logic              illegal,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    logic [ADDR_W-1:0] r_upc;
    logic [OP_W-1:0]   r_op_q;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_count;

    logic [ADDR_W-1:0] w_next_upc;
    logic [OP_W-1:0]   w_next_op_q;
    logic              w_next_illegal;
    logic [CNT_W-1:0]  w_next_count;
    logic [ADDR_W-1:0] w_d1_addr;
    logic              w_d1_hit;
    logic [ADDR_W-1:0] w_d2_addr;
    logic              w_d2_hit;

    // Stage 1 decodes the live opcode; stage 2 decodes the opcode latched at stage 1.
    dispatch_rom #(.TABLE(1), .ADDR_W(ADDR_W), .OP_W(OP_W)) u_disp1 (
        .i_op_code (op_code),
        .o_addr    (w_d1_addr),
        .o_hit     (w_d1_hit)
    );

    dispatch_rom #(.TABLE(2), .ADDR_W(ADDR_W), .OP_W(OP_W)) u_disp2 (
        .i_op_code (r_op_q),
        .o_addr    (w_d2_addr),
        .o_hit     (w_d2_hit)
    );

    // Next-state selection; the trap address is absorbing, and stall freezes everything.
    always_comb begin
        w_next_upc     = r_upc;
        w_next_op_q    = r_op_q;
        w_next_illegal = r_illegal;
        w_next_count   = r_count;
        if (r_upc == TRAP_ADDR) begin
            w_next_upc = r_upc;
        end else if (stall) begin
            w_next_upc = r_upc;
        end else begin
            case (addr_ctl)
                AC_FETCH: begin
                    w_next_upc   = {ADDR_W{1'b0}};
                    w_next_count = r_count + CNT_W'(1);
                end
                AC_DISP1: begin
                    w_next_op_q    = op_code;
                    w_next_upc     = w_d1_hit ? w_d1_addr : TRAP_ADDR;
                    w_next_illegal = r_illegal | ~w_d1_hit;
                end
                AC_DISP2: begin
                    w_next_upc     = w_d2_hit ? w_d2_addr : TRAP_ADDR;
                    w_next_illegal = r_illegal | ~w_d2_hit;
                end
                AC_SEQ: begin
                    w_next_upc = r_upc + ADDR_W'(1);
                end
                default: begin
                    w_next_upc = r_upc;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upc     <= {ADDR_W{1'b0}};
            r_op_q    <= {OP_W{1'b0}};
            r_illegal <= 1'b0;
            r_count   <= {CNT_W{1'b0}};
        end else begin
            r_upc     <= w_next_upc;
            r_op_q    <= w_next_op_q;
            r_illegal <= w_next_illegal;
            r_count   <= w_next_count;
        end
    end

    assign upc         = r_upc;
    assign illegal     = r_illegal;
    assign halted      = (r_upc == TRAP_ADDR);
    assign instr_count = r_count;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a reference model pushes expected state
// into a queue on each drive; the popped entry is compared after the clock edge.
module tb_micro_sequencer;

    typedef struct {
        logic [3:0]  upc;
        logic        illegal;
        logic        halted;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  op_code = 6'd0;
    logic [1:0]  addr_ctl = 2'd0;
    logic        stall = 1'b0;
    logic [3:0]  upc, upc2;
    logic        illegal, illegal2, halted, halted2;
    logic [15:0] instr_count;
    logic [1:0]  instr_count2;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    // reference model state
    logic [3:0]  m_upc = 4'd0;
    logic [5:0]  m_op_q = 6'd0;
    logic        m_ill = 1'b0;
    logic [15:0] m_cnt = 16'd0;

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk(clk), .rst(rst), .op_code(op_code), .addr_ctl(addr_ctl), .stall(stall),
        .upc(upc), .illegal(illegal), .halted(halted), .instr_count(instr_count)
    );

    micro_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .op_code(op_code), .addr_ctl(addr_ctl), .stall(stall),
        .upc(upc2), .illegal(illegal2), .halted(halted2), .instr_count(instr_count2)
    );

    function automatic void model_step(input logic r, input logic [1:0] ac,
                                       input logic [5:0] op, input logic st);
        if (r) begin
            m_upc = 4'd0; m_op_q = 6'd0; m_ill = 1'b0; m_cnt = 16'd0;
        end else if (m_upc == 4'd15 || st) begin
            m_upc = m_upc;
        end else if (ac == 2'd0) begin
            m_upc = 4'd0; m_cnt = m_cnt + 16'd1;
        end else if (ac == 2'd3) begin
            m_upc = m_upc + 4'd1;
        end else if (ac == 2'd1) begin
            m_op_q = op;
            case (op)
                6'b000000: m_upc = 4'd6;
                6'b000010: m_upc = 4'd9;
                6'b000100: m_upc = 4'd8;
                6'b100011: m_upc = 4'd2;
                6'b101011: m_upc = 4'd2;
                default:   begin m_upc = 4'd15; m_ill = 1'b1; end
            endcase
        end else begin
            case (m_op_q)
                6'b100011: m_upc = 4'd3;
                6'b101011: m_upc = 4'd5;
                default:   begin m_upc = 4'd15; m_ill = 1'b1; end
            endcase
        end
    endfunction

    task automatic step(input logic r, input logic [1:0] ac, input logic [5:0] op,
                        input logic st, input string tag);
        exp_t e;
        rst = r; addr_ctl = ac; op_code = op; stall = st;
        model_step(r, ac, op, st);
        e.upc = m_upc; e.illegal = m_ill; e.halted = (m_upc == 4'd15);
        e.cnt = m_cnt; e.cnt2 = m_cnt[1:0];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_checks += 5;
        assert (upc === e.upc) else begin
            n_fail++; $error("FAIL %s upc: observed %0d expected %0d", tag, upc, e.upc);
        end
        assert (illegal === e.illegal) else begin
            n_fail++; $error("FAIL %s illegal: observed %0b expected %0b", tag, illegal, e.illegal);
        end
        assert (halted === e.halted) else begin
            n_fail++; $error("FAIL %s halted: observed %0b expected %0b", tag, halted, e.halted);
        end
        assert (instr_count === e.cnt) else begin
            n_fail++; $error("FAIL %s count: observed %0d expected %0d", tag, instr_count, e.cnt);
        end
        assert ({upc2, illegal2, halted2, instr_count2} === {e.upc, e.illegal, e.halted, e.cnt2}) else begin
            n_fail++; $error("FAIL %s narrow: observed upc %0d cnt %0d expected upc %0d cnt %0d",
                             tag, upc2, instr_count2, e.upc, e.cnt2);
        end
    endtask

    initial begin
        @(negedge clk);
        step(1'b1, 2'd3, 6'd0, 1'b0, "reset");
        // basic sequencing and two-stage dispatch
        step(1'b0, 2'd3, 6'b100011, 1'b0, "seq0");
        step(1'b0, 2'd1, 6'b100011, 1'b0, "disp1_lw");
        step(1'b0, 2'd3, 6'b100011, 1'b0, "seq2");
        step(1'b1, 2'd3, 6'd0, 1'b0, "reset2");
        step(1'b0, 2'd3, 6'b100011, 1'b0, "seq0b");
        step(1'b0, 2'd1, 6'b100011, 1'b0, "disp1_lw_b");
        step(1'b0, 2'd2, 6'b100011, 1'b0, "disp2_lw");
        // table 1 coverage
        step(1'b0, 2'd1, 6'b000000, 1'b0, "disp1_rtype");
        step(1'b0, 2'd1, 6'b000010, 1'b0, "disp1_j");
        step(1'b0, 2'd1, 6'b000100, 1'b0, "disp1_beq");
        step(1'b0, 2'd1, 6'b101011, 1'b0, "disp1_sw");
        // latched opcode used by stage 2
        step(1'b0, 2'd2, 6'b100011, 1'b0, "disp2_latched");
        // stall at upc 6
        step(1'b0, 2'd1, 6'b000000, 1'b0, "to6");
        for (int i = 0; i < 3; i++) step(1'b0, 2'd3, 6'd0, 1'b1, "stall");
        step(1'b0, 2'd3, 6'd0, 1'b0, "after_stall");
        step(1'b0, 2'd3, 6'd0, 1'b1, "stall_again");
        step(1'b1, 2'd3, 6'd0, 1'b1, "reset_in_stall");
        // counter and narrow-counter wrap
        for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 6'd0, 1'b0, "fetch");
        // SEQ walk into the trap address does not set illegal
        step(1'b0, 2'd1, 6'b000010, 1'b0, "to9");
        for (int i = 0; i < 6; i++) step(1'b0, 2'd3, 6'd0, 1'b0, "seq_to_trap");
        step(1'b0, 2'd0, 6'd0, 1'b0, "halted_fetch");
        step(1'b1, 2'd3, 6'd0, 1'b0, "reset3");
        // illegal opcode trap is sticky until reset
        step(1'b0, 2'd1, 6'b111111, 1'b0, "disp1_illegal");
        step(1'b0, 2'd3, 6'd0, 1'b0, "trap_seq");
        step(1'b0, 2'd0, 6'd0, 1'b0, "trap_fetch");
        step(1'b0, 2'd1, 6'b000000, 1'b0, "trap_disp1");
        step(1'b1, 2'd3, 6'd0, 1'b0, "reset4");
        // stage-2 miss traps too
        step(1'b0, 2'd1, 6'b000100, 1'b0, "disp1_beq2");
        step(1'b0, 2'd2, 6'b000100, 1'b0, "disp2_illegal");
        step(1'b1, 2'd0, 6'd0, 1'b0, "reset5");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
